// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module : dm_pkg
// Purpose: Shared types and helpers for the data memory controller.
//          - dm_state_e        : controller FSM states (idle / array clear)
//          - CLOG2             : ceiling log2 for counter / index widths
//          - DM_RD_LAT_LEGAL() : elaboration check for the read latency
// Rev    : 1.0  initial release
// ============================================================================

// True when the read latency is one of the two supported pipeline depths.
`ifndef DM_RD_LAT_LEGAL
`define DM_RD_LAT_LEGAL(lat) (((lat) == 1) || ((lat) == 2))
`endif

package dm_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } dm_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
// Module : dm_ram
// Purpose: DEPTH x DATA_W synchronous single-port array, per-byte write
//          enables, registered read port. No reset on storage or read data.
// Ports  : clk      - clock
//          i_we     - per-byte write enable (DATA_W/8 bits)
//          i_addr   - word index
//          i_wdata  - write data
//          i_re     - read enable; read register updates only when set
//          o_rdata  - registered read data
// Rev    : 1.0  initial release
// ============================================================================
module dm_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                  clk,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl
// Purpose: Data memory controller for the RISC datapath. Valid/ready request
//          port, byte-enable writes, 1- or 2-cycle read latency, out-of-range
//          detection, and a clear engine that zeroes the array after reset
//          (CLR_ON_RST=1) and on clr_start.
// Ports  : clk, rst (async, active-low)
//          req_valid/req_ready/req_we/req_be/req_addr/req_wdata - request
//          rsp_valid/rsp_rdata/rsp_err                          - response
//          clr_start (in), clr_busy (out)                       - clear engine
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DATA_W/8-1:0]  req_be,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  input  logic                 clr_start,
  output logic                 clr_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (CLOG2(DEPTH) < 1) ? 1 : CLOG2(DEPTH);
  localparam logic [CNT_W-1:0]  C_LAST      = CNT_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   C_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  if (!`DM_RD_LAT_LEGAL(RD_LAT)) begin : g_bad_rd_lat
    $error("data_mem_ctrl: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("data_mem_ctrl: DATA_W must be a multiple of 8");
  end

  dm_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_in_range;
  logic [NB-1:0]     w_ram_we;
  logic [CNT_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_q;

  // Full-width compare: high address bits are never dropped, so an
  // out-of-range address can never alias onto a legal word.
  assign w_in_range = ({1'b0, req_addr} < C_DEPTH_EXT);
  assign w_accept   = req_valid && (r_state == S_IDLE);

  assign req_ready = (r_state == S_IDLE);
  assign clr_busy  = (r_state == S_CLEAR);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_cnt   <= '0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------- write/clear mux into array
  // No request is ever accepted while clearing, so the clear owns the port.
  always_comb begin
    w_ram_we    = '0;
    w_ram_addr  = req_addr[CNT_W-1:0];
    w_ram_wdata = req_wdata;
    w_ram_re    = 1'b0;
    if (r_state == S_CLEAR) begin
      w_ram_we    = '1;
      w_ram_addr  = r_cnt;
      w_ram_wdata = '0;
    end else if (w_accept && w_in_range) begin
      if (req_we) w_ram_we = req_be;
      else        w_ram_re = 1'b1;
    end
  end

  dm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CNT_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .o_rdata (w_ram_q)
  );

  // ---------------------------------------------------- response pipeline
  logic r_v1;
  logic r_err1;
  logic r_rd1;      // stage 1 carries an in-range read; array data is valid
  logic [DATA_W-1:0] w_data1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_err1 <= 1'b0;
      r_rd1  <= 1'b0;
    end else begin
      r_v1   <= w_accept;
      r_err1 <= w_accept && !w_in_range;
      r_rd1  <= w_accept && !req_we && w_in_range;
    end
  end

  // The array read register has no reset; masking keeps X off the output.
  assign w_data1 = r_rd1 ? w_ram_q : '0;

  if (RD_LAT == 2) begin : g_lat2
    logic              r_v2;
    logic              r_err2;
    logic [DATA_W-1:0] r_data2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v2    <= 1'b0;
        r_err2  <= 1'b0;
        r_data2 <= '0;
      end else begin
        r_v2    <= r_v1;
        r_err2  <= r_err1;
        r_data2 <= w_data1;
      end
    end

    assign rsp_valid = r_v2;
    assign rsp_err   = r_err2;
    assign rsp_rdata = r_data2;
  end else begin : g_lat1
    assign rsp_valid = r_v1;
    assign rsp_err   = r_err1;
    assign rsp_rdata = w_data1;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_ctrl
// Purpose: Self-checking bench for data_mem_ctrl. Two instances (RD_LAT=1 and
//          RD_LAT=2) share one stimulus stream; each has its own expected
//          response queue filled from a reference memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          clr_start;

  logic          rdy1, rv1, err1, busy1;
  logic [DW-1:0] rd1;
  logic          rdy2, rv2, err2, busy2;
  logic [DW-1:0] rd2;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic [15:0] model [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .CLR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_err(err1), .clr_start(clr_start), .clr_busy(busy1)
  );

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2), .CLR_ON_RST(1)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_err(err2), .clr_start(clr_start), .clr_busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ----------------------------------------------------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (rv1) begin
      check("L1_rsp_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("L1_rsp_cycle", cyc, e.cyc);
        check("L1_rsp_err", 32'(err1), 32'(e.err));
        check("L1_rsp_data", 32'(rd1), 32'(e.data));
      end
    end else begin
      check("L1_idle_rdata", 32'(rd1), 0);
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        check("L1_rsp_on_time", 0, 1);
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rv2) begin
      check("L2_rsp_expected", 32'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("L2_rsp_cycle", cyc, e.cyc);
        check("L2_rsp_err", 32'(err2), 32'(e.err));
        check("L2_rsp_data", 32'(rd2), 32'(e.data));
      end
    end else begin
      check("L2_idle_rdata", 32'(rd2), 0);
      if (q2.size() > 0 && q2[0].cyc <= cyc) begin
        check("L2_rsp_on_time", 0, 1);
        void'(q2.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
  endtask

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic we, input logic [1:0] be, input logic [15:0] a,
                       input logic [15:0] d, input logic cs);
    exp_t e;
    logic in;
    check("req_ready_L1", 32'(rdy1), 1);
    check("req_ready_L2", 32'(rdy2), 1);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = d;
    clr_start = cs;
    in     = (a < 16'(DEPTH));
    e.err  = !in;
    e.data = (!we && in) ? model[a[9:0]] : 16'h0000;
    if (we && in) begin
      if (be[0]) model[a[9:0]][7:0]  = d[7:0];
      if (be[1]) model[a[9:0]][15:8] = d[15:8];
    end
    e.cyc = cyc + 1;
    q1.push_back(e);
    e.cyc = cyc + 2;
    q2.push_back(e);
    @(negedge clk);
  endtask

  // Counts negedges (starting with the current one) on which the clear is busy.
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 3000) begin
      check("busy_match", 32'(busy2), 32'(busy1));
      n++;
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n;
    rst = 1'b0;
    idle();
    model_clear();
    cycles(3);

    // Reset state
    check("rst_rsp_valid", 32'({rv1, rv2}), 0);
    check("rst_rsp_rdata", 32'({rd1, rd2}), 0);
    check("rst_rsp_err", 32'({err1, err2}), 0);
    check("rst_clr_busy", 32'({busy1, busy2}), 32'b11);
    check("rst_req_ready", 32'({rdy1, rdy2}), 0);

    // 1. post-reset clear lasts exactly DEPTH cycles, then a read returns 0
    rst = 1'b1;
    count_busy(n);
    check("clr_after_reset_len", n, DEPTH);
    check("ready_after_clear", 32'({rdy1, rdy2}), 32'b11);
    issue(1'b0, 2'b00, 16'd5, 16'h0000, 1'b0);
    idle();
    cycles(3);

    // 2. full write, low-byte write, read merged word
    issue(1'b1, 2'b11, 16'd10, 16'hABCD, 1'b0);
    issue(1'b1, 2'b01, 16'd10, 16'h0012, 1'b0);
    issue(1'b0, 2'b00, 16'd10, 16'h0000, 1'b0);
    idle();
    cycles(3);

    // 3. back-to-back writes then back-to-back reads; be=0 write is a no-op
    issue(1'b1, 2'b11, 16'd1, 16'h0011, 1'b0);
    issue(1'b1, 2'b11, 16'd2, 16'h0022, 1'b0);
    issue(1'b1, 2'b11, 16'd3, 16'h0033, 1'b0);
    issue(1'b1, 2'b00, 16'd2, 16'hFFFF, 1'b0);
    issue(1'b0, 2'b00, 16'd1, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 16'd2, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 16'd3, 16'h0000, 1'b0);
    idle();
    cycles(4);

    // 4. out-of-range accesses: error, zero data, no aliasing onto low words
    issue(1'b1, 2'b11, 16'd0, 16'h0BEE, 1'b0);
    issue(1'b0, 2'b00, 16'd1024, 16'h0000, 1'b0);
    issue(1'b1, 2'b11, 16'hFFFF, 16'h5555, 1'b0);
    issue(1'b1, 2'b11, 16'd1024, 16'h7777, 1'b0);
    issue(1'b0, 2'b00, 16'd0, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 16'd1023, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 16'd1023, 16'h0000, 1'b0);
    idle();
    cycles(4);

    // 5. request coincident with clr_start: response delivered, then full clear
    issue(1'b1, 2'b11, 16'd7, 16'h7777, 1'b0);
    issue(1'b0, 2'b00, 16'd10, 16'h0000, 1'b1);
    idle();
    model_clear();
    n = 0;
    while (busy1 && n < 3000) begin
      check("clear_ready_low", 32'(rdy1), 0);
      clr_start = (n == 500);      // ignored while clearing
      req_valid = (n == 600);      // must not be accepted while clearing
      n++;
      @(negedge clk);
    end
    idle();
    check("clr_start_len", n, DEPTH);
    issue(1'b0, 2'b00, 16'd10, 16'h0000, 1'b0);
    issue(1'b0, 2'b00, 16'd7, 16'h0000, 1'b0);
    idle();
    cycles(3);

    // 6. reset in the middle of a clear restarts it from word 0
    issue(1'b1, 2'b11, 16'd3, 16'h1234, 1'b0);
    idle();
    cycles(2);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    cycles(300);
    check("mid_clear_busy", 32'(busy1), 1);
    rst = 1'b0;
    cycles(2);
    check("mid_clear_rst_busy", 32'({busy1, busy2}), 32'b11);
    rst = 1'b1;
    count_busy(n);
    check("clr_restart_len", n, DEPTH);
    model_clear();
    issue(1'b0, 2'b00, 16'd3, 16'h0000, 1'b0);
    idle();
    cycles(3);

    // 7. reset with a response in flight drops it asynchronously
    issue(1'b1, 2'b11, 16'd4, 16'h4444, 1'b0);
    issue(1'b0, 2'b00, 16'd4, 16'h0000, 1'b0);
    idle();
    #1;
    rst = 1'b0;
    q2.delete();
    #1;
    check("async_rst_valid_L1", 32'(rv1), 0);
    check("async_rst_ready", 32'({rdy1, rdy2}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    check("clr_after_rst2_len", n, DEPTH);
    model_clear();
    issue(1'b0, 2'b00, 16'd4, 16'h0000, 1'b0);
    idle();
    cycles(5);

    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
